// File: rtl/fraction_mac_sequencer_if.sv
// Operand handshake, multiplier link and batch-result signals of the
// fraction MAC sequencer.
interface fraction_mac_sequencer_if #(
  parameter int ACC_W = 10
);
  logic             In_Valid;
  logic             In_Ready;
  logic [3:0]       In_Mplier;
  logic [3:0]       In_Mcand;
  logic             In_Last;
  logic             Mul_St;
  logic [3:0]       Mul_Mplier;
  logic [3:0]       Mul_Mcand;
  logic [6:0]       Mul_Product;
  logic             Mul_Done;
  logic [ACC_W-1:0] Acc_Out;
  logic [3:0]       Result;
  logic             Result_Valid;
  logic             Overflow;

  modport master (
    output In_Valid, In_Mplier, In_Mcand, In_Last, Mul_Product, Mul_Done,
    input  In_Ready, Mul_St, Mul_Mplier, Mul_Mcand, Acc_Out, Result,
           Result_Valid, Overflow
  );

  modport slave (
    input  In_Valid, In_Mplier, In_Mcand, In_Last, Mul_Product, Mul_Done,
    output In_Ready, Mul_St, Mul_Mplier, Mul_Mcand, Acc_Out, Result,
           Result_Valid, Overflow
  );
endinterface

// File: rtl/fraction_mac_sequencer.sv
// Feeds Q0.3 operand pairs to the shift-add fraction multiplier and
// accumulates its Q0.6 products into a saturating batch dot product.
//
// state   | meaning
// S_FLUSH | after reset, ignore the (unreset) multiplier for FLUSH_CYC cycles
// S_IDLE  | ready for an operand pair
// S_START | Mul_St high for this single cycle
// S_WAIT  | waiting for Mul_Done, then accumulate
// S_OUT   | round and publish the batch result, clear the accumulator
module fraction_mac_sequencer #(
  parameter int ACC_W     = 10,
  parameter int FLUSH_CYC = 6
) (
  input logic                    CLK,
  input logic                    RST,
  fraction_mac_sequencer_if.slave bus
);
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t           state;
  logic [FW-1:0]    flush_cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_r;
  logic             last_r;
  logic             mul_st;
  logic [3:0]       mul_mplier;
  logic [3:0]       mul_mcand;
  logic [3:0]       result;
  logic             result_valid;
  logic             overflow;

  logic [ACC_W:0]   sum;
  logic             acc_sat;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-3:0] shf;
  logic [ACC_W-6:0] shf_hi;
  logic             in_rng;
  logic [3:0]       res_q;

  assign sum      = {acc[ACC_W-1], acc}
                  + {{(ACC_W-6){bus.Mul_Product[6]}}, bus.Mul_Product};
  assign acc_sat  = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_next = acc_sat ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}}
                            : sum[ACC_W-1:0];

  // (acc + 4) >>> 3 equals (acc >>> 3) plus the carry out of bit 2
  assign shf    = {acc[ACC_W-1], acc[ACC_W-1:3]} + {{(ACC_W-3){1'b0}}, acc[2]};
  assign shf_hi = shf[ACC_W-3:3];
  assign in_rng = (&shf_hi) | ~(|shf_hi);
  assign res_q  = in_rng ? shf[3:0] : (shf[ACC_W-3] ? 4'b1000 : 4'b0111);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_FLUSH;
      flush_cnt    <= FW'(FLUSH_CYC - 1);
      acc          <= '0;
      ovf_r        <= 1'b0;
      last_r       <= 1'b0;
      mul_st       <= 1'b0;
      mul_mplier   <= '0;
      mul_mcand    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      mul_st       <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_FLUSH: begin
          if (flush_cnt == '0) state <= S_IDLE;
          else flush_cnt <= flush_cnt - 1'b1;
        end
        S_IDLE: begin
          if (bus.In_Valid) begin
            mul_mplier <= bus.In_Mplier;
            mul_mcand  <= bus.In_Mcand;
            last_r     <= bus.In_Last;
            mul_st     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (bus.Mul_Done) begin
            acc <= acc_next;
            if (acc_sat) ovf_r <= 1'b1;
            state <= last_r ? S_OUT : S_IDLE;
          end
        end
        S_OUT: begin
          result       <= res_q;
          overflow     <= ovf_r | ~in_rng;
          result_valid <= 1'b1;
          acc          <= '0;
          ovf_r        <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

  assign bus.In_Ready     = (state == S_IDLE);
  assign bus.Mul_St       = mul_st;
  assign bus.Mul_Mplier   = mul_mplier;
  assign bus.Mul_Mcand    = mul_mcand;
  assign bus.Acc_Out      = acc;
  assign bus.Result       = result;
  assign bus.Result_Valid = result_valid;
  assign bus.Overflow     = overflow;
endmodule
